// File: rtl/ndp_pkg.sv
// Shared sizing helpers and drain state encoding for the NDP result drain.
package ndp_pkg;

   typedef logic [1:0] drain_state_t;

   localparam drain_state_t ST_IDLE = 2'd0;
   localparam drain_state_t ST_SEND = 2'd1;
   localparam drain_state_t ST_DONE = 2'd2;

   // Ceiling log2, never below 1 so an index port always has a bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int unsigned calc_elems(input int unsigned arr_w, input int unsigned arr_h,
                                              input int unsigned sys_w, input int unsigned sys_h);
      return arr_w * sys_w * arr_h * sys_h;
   endfunction

   function automatic int unsigned calc_total_bits(input int unsigned elems, input int unsigned width);
      return elems * width;
   endfunction

   function automatic int unsigned calc_words(input int unsigned total_bits, input int unsigned out_width);
      return total_bits / out_width;
   endfunction

   function automatic int unsigned calc_idx_w(input int unsigned words);
      return clog2(words);
   endfunction

endpackage

// File: rtl/ndp_relu_lane.sv
// Per-element ReLU clamp: any element with its sign bit set is stored as zero.
module ndp_relu_lane #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] elem,
   output logic [WIDTH-1:0] relu_c
);

   assign relu_c = elem[WIDTH-1] ? '0 : elem;

endmodule

// File: rtl/ndp_result_drain.sv
// Captures the core result bus on calc-done and streams it out OUT_WIDTH bits at a time.
// Optional ReLU at capture time when NDP_DRAIN_RELU_EN is defined.
module ndp_result_drain
   import ndp_pkg::*;
#(
   parameter  int unsigned WIDTH      = 16,
   parameter  int unsigned IS_FLOAT   = 1,
   parameter  int unsigned ARR_WIDTH  = 4,
   parameter  int unsigned ARR_HEIGHT = 4,
   parameter  int unsigned SYS_WIDTH  = 64,
   parameter  int unsigned SYS_HEIGHT = 1,
   parameter  int unsigned OUT_WIDTH  = 32,
   localparam int unsigned ELEMS      = calc_elems(ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT),
   localparam int unsigned TOTAL_BITS = calc_total_bits(ELEMS, WIDTH),
   localparam int unsigned WORDS      = calc_words(TOTAL_BITS, OUT_WIDTH),
   localparam int unsigned IDX_W      = calc_idx_w(WORDS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  calc_done_flag,
   input  logic [TOTAL_BITS-1:0] in_c,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_last,
   output logic [IDX_W-1:0]      word_idx,
   output logic                  busy,
   output logic                  drain_done
);

   // The sign-bit clamp is the same for float and integer elements.
   localparam bit unused_is_float = (IS_FLOAT != 0);

   logic [TOTAL_BITS-1:0]               cap_in_c;
   logic [WORDS-1:0][OUT_WIDTH-1:0]     cap_in_words;
   logic [WORDS-1:0][OUT_WIDTH-1:0]     cap_q;

   drain_state_t         state_q;
   drain_state_t         state_d;
   logic                 done_q;
   logic [IDX_W-1:0]     idx_d;
   logic [OUT_WIDTH-1:0] out_data_d;
   logic                 out_last_d;
   logic                 cap_load;
   logic                 rise;
   logic                 xfer;

`ifdef NDP_DRAIN_RELU_EN
   for (genvar e = 0; e < ELEMS; e++) begin : g_relu
      ndp_relu_lane #(.WIDTH(WIDTH)) u_lane (
         .elem   (in_c[e*WIDTH +: WIDTH]),
         .relu_c (cap_in_c[e*WIDTH +: WIDTH])
      );
   end
`else
   assign cap_in_c = in_c;
`endif

   assign cap_in_words = cap_in_c;

   // Next state, index and registered-output values.
   always_comb begin
      state_d    = state_q;
      idx_d      = word_idx;
      out_data_d = out_data;
      cap_load   = 1'b0;
      rise       = calc_done_flag & ~done_q;
      xfer       = out_valid & out_ready;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               cap_load   = 1'b1;
               idx_d      = '0;
               out_data_d = cap_in_words[0];
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (word_idx == IDX_W'(WORDS - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d      = word_idx + 1'b1;
                  out_data_d = cap_q[idx_d];
               end
            end
         end
         ST_DONE: begin
            if (!calc_done_flag) begin
               idx_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      out_last_d = (state_d == ST_SEND) && (idx_d == IDX_W'(WORDS - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         cap_q      <= '0;
         word_idx   <= '0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         drain_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= calc_done_flag;
         if (cap_load) cap_q <= cap_in_words;
         word_idx   <= idx_d;
         out_data   <= out_data_d;
         out_last   <= out_last_d;
         out_valid  <= (state_d == ST_SEND);
         busy       <= (state_d == ST_SEND);
         drain_done <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Randomized bench for ndp_result_drain against an element-level reference model.
module tb_ndp_result_drain;

   localparam int unsigned WIDTH      = 16;
   localparam int unsigned OUT_WIDTH  = 32;
   localparam int unsigned LANES      = OUT_WIDTH / WIDTH;
   localparam int unsigned ELEMS      = 1024;
   localparam int unsigned TOTAL_BITS = ELEMS * WIDTH;
   localparam int unsigned WORDS      = TOTAL_BITS / OUT_WIDTH;
   localparam int unsigned IDX_W      = 9;

   logic                  clk;
   logic                  clk_en;
   logic                  reset;
   logic                  calc_done_flag;
   logic [TOTAL_BITS-1:0] in_c;
   logic                  out_valid;
   logic                  out_ready;
   logic [OUT_WIDTH-1:0]  out_data;
   logic                  out_last;
   logic [IDX_W-1:0]      word_idx;
   logic                  busy;
   logic                  drain_done;

   logic [WIDTH-1:0] elem_m [ELEMS];
   int n_checks;
   int n_pass;

   ndp_result_drain dut (
      .clk            (clk),
      .reset          (reset),
      .calc_done_flag (calc_done_flag),
      .in_c           (in_c),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .word_idx       (word_idx),
      .busy           (busy),
      .drain_done     (drain_done)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Expected word w from the captured elements: element j of the word in the low bits first.
   function automatic logic [OUT_WIDTH-1:0] exp_word(input int w);
      logic [OUT_WIDTH-1:0] r;
      logic [WIDTH-1:0]     e;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         e = elem_m[w*LANES + k];
`ifdef NDP_DRAIN_RELU_EN
         if (e[WIDTH-1]) e = '0;
`endif
         r[k*WIDTH +: WIDTH] = e;
      end
      return r;
   endfunction

   // pat 0: element i = i; 1: random; 2: random with 0x8001, 0x3C00 in elements 0 and 1.
   task automatic start_capture(input int pat);
      calc_done_flag = 1'b0;
      @(negedge clk);
      check("idle_valid", out_valid, 0);
      for (int i = 0; i < ELEMS; i++)
         elem_m[i] = (pat == 0) ? WIDTH'(i) : WIDTH'($urandom);
      if (pat == 2) begin
         elem_m[0] = 16'h8001;
         elem_m[1] = 16'h3C00;
      end
      for (int i = 0; i < ELEMS; i++)
         in_c[i*WIDTH +: WIDTH] = elem_m[i];
      calc_done_flag = 1'b1;
      @(negedge clk);
      check("cap_valid", out_valid, 1);
      check("cap_busy", busy, 1);
      check("cap_idx", word_idx, 0);
   endtask

   // mode 0: ready always 1; 1: random ready. stall_at: hold ready low 5 cycles at that index.
   task automatic run_drain(input int mode, input int stop_n, input int stall_at, input bit mid_change);
      int  n;
      int  budget;
      int  stall;
      bit  pulsed;
      bit  rdy;
      n = 0; budget = 0; stall = 0; pulsed = 0;
      while (n < stop_n && budget < 20000) begin
         rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (n == stall_at && stall < 5) begin
            rdy = 1'b0;
            stall++;
         end
         out_ready = rdy;
         check("valid", out_valid, 1);
         check("busy", busy, 1);
         check("done_low", drain_done, 0);
         check("data", out_data, exp_word(n));
         check("idx", word_idx, n);
         check("last", out_last, (n == WORDS - 1));
         if (mid_change) begin
            if (n == 50 && !pulsed) begin
               in_c           = '1;
               calc_done_flag = 1'b0;
               pulsed         = 1'b1;
            end else if (pulsed) begin
               calc_done_flag = 1'b1;
            end
         end
         if (rdy) n++;
         @(negedge clk);
         budget++;
      end
      if (n < stop_n) check("drain_timeout", n, stop_n);
      if (stop_n == WORDS) begin
         check("end_valid", out_valid, 0);
         check("end_done", drain_done, 1);
         check("end_busy", busy, 0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      clk = 1'b0; clk_en = 1'b1;
      reset = 1'b1; calc_done_flag = 1'b0; in_c = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", drain_done, 0);
      check("rst_idx", word_idx, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic drain plus handshake back to IDLE.
      start_capture(0);
      check("w0_const", out_data, 32'h00010000);
      run_drain(0, WORDS, -1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("hold_done", drain_done, 1);
      end
      calc_done_flag = 1'b0;
      @(negedge clk);
      check("drop_done", drain_done, 0);
      check("drop_valid", out_valid, 0);

      // Backpressure at word 10.
      start_capture(0);
      run_drain(0, WORDS, 10, 1'b0);

      // Capture isolation and re-trigger during the drain.
      start_capture(1);
      run_drain(1, WORDS, -1, 1'b1);

      // Reset mid-drain with the clock stopped.
      start_capture(1);
      run_drain(0, 100, -1, 1'b0);
      check("pre_rst_idx", word_idx, 100);
      clk_en = 1'b0;
      #3 reset = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_idx", word_idx, 0);
      check("arst_data", out_data, 0);
      check("arst_last", out_last, 0);
      #2 reset = 1'b0;
      #1 clk_en = 1'b1;
      start_capture(1);
      run_drain(1, WORDS, -1, 1'b0);

      // ReLU pattern.
      start_capture(2);
`ifdef NDP_DRAIN_RELU_EN
      check("relu_w0", out_data, 32'h3C000000);
`else
      check("raw_w0", out_data, 32'h3C008001);
`endif
      run_drain(0, WORDS, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
